// File: rtl/idct_pkg.sv
// Shared sizing for the IDCT transpose buffer.
// Holds sample width, block dimension, address width and block size.
package idct_pkg;

  localparam int DW  = 16;
  localparam int N   = 8;
  localparam int LN  = $clog2(N);
  localparam int AW  = 2 * LN;
  localparam int BLK = N * N;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] samp_t;

  // Row-major address of column-major position p: swap row/col fields.
  function automatic addr_t tpose_addr(input addr_t p);
    return {p[LN-1:0], p[AW-1:LN]};
  endfunction

endpackage

// File: rtl/idct_tpose_bank.sv
// One N*N x DW sample bank: synchronous write, asynchronous read.
// Ports: clk, we/waddr/wdata write side, raddr -> rdata read side.
module idct_tpose_bank
  import idct_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  addr_t waddr,
  input  samp_t wdata,
  input  addr_t raddr,
  output samp_t rdata
);

  samp_t mem [BLK];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/idct_transpose_buf.sv
// Ping-pong transpose buffer: N*N blocks in row-major, out column-major.
// Ports: clk, rst_n, in_* (valid/ready/sob/data), out_* (valid/ready/data/sob/eob), err_resync.
module idct_transpose_buf
  import idct_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sob,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sob,
  output logic          out_eob,
  output logic          err_resync
);

  localparam addr_t LAST = addr_t'(BLK - 1);

  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       wb;
  logic       rb;
  addr_t      wr_ptr;
  addr_t      rd_ptr;

  logic  wr_fire;
  logic  resync;
  logic  wr_last;
  logic  rd_fire;
  logic  rd_last;
  addr_t waddr;
  addr_t addr_rd;
  samp_t rdata0;
  samp_t rdata1;
  samp_t rdata;

  assign in_ready  = !full[wb];
  assign out_valid = full[rb];

  assign wr_fire = in_valid & in_ready;
  // An early start-of-block restarts the bank at address 0.
  assign resync  = wr_fire & in_sob & (wr_ptr != '0);
  assign wr_last = wr_fire & !resync & (wr_ptr == LAST);
  assign waddr   = resync ? '0 : wr_ptr;

  assign rd_fire = out_valid & out_ready;
  assign rd_last = rd_fire & (rd_ptr == LAST);
  assign addr_rd = tpose_addr(rd_ptr);

  idct_tpose_bank u_bank0 (
    .clk   (clk),
    .we    (wr_fire & !wb),
    .waddr (waddr),
    .wdata (in_data),
    .raddr (addr_rd),
    .rdata (rdata0)
  );

  idct_tpose_bank u_bank1 (
    .clk   (clk),
    .we    (wr_fire & wb),
    .waddr (waddr),
    .wdata (in_data),
    .raddr (addr_rd),
    .rdata (rdata1)
  );

  assign rdata = rb ? rdata1 : rdata0;

  // Bank contents are unreset; gate so idle output reads as zero.
  assign out_data = out_valid ? rdata : '0;
  assign out_sob  = out_valid & (rd_ptr == '0);
  assign out_eob  = out_valid & (rd_ptr == LAST);

  // Writes need !full and reads need full, so set/clear never collide.
  always_comb begin
    full_nxt = full;
    if (wr_last) begin
      full_nxt[wb] = 1'b1;
    end
    if (rd_last) begin
      full_nxt[rb] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full       <= '0;
      wb         <= 1'b0;
      rb         <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_resync <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        unique case (1'b1)
          resync: begin
            wr_ptr     <= addr_t'(1);
            err_resync <= 1'b1;
          end
          wr_last: begin
            wr_ptr <= '0;
            wb     <= ~wb;
          end
          default: begin
            wr_ptr <= wr_ptr + 1'b1;
          end
        endcase
      end
      if (rd_fire) begin
        if (rd_last) begin
          rd_ptr <= '0;
          rb     <= ~rb;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_idct_transpose_buf.sv
// Self-checking bench for idct_transpose_buf.
// Directed tables plus stream runs against a transpose reference.
module tb_idct_transpose_buf;
  import idct_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_sob;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sob;
  logic          out_eob;
  logic          err_resync;

  idct_transpose_buf dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sob     (in_sob),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sob    (out_sob),
    .out_eob    (out_eob),
    .err_resync (err_resync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int data;
    bit sob;
    bit eob;
  } vec_t;

  vec_t tbl [8];

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] src   [$];
  bit            sobq  [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got   [$];

  int rec_d [BLK];
  bit rec_s [BLK];
  bit rec_e [BLK];

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Column-major position j of a block holds row-major element tidx(j).
  function automatic int tidx(input int j);
    return (j % N) * N + j / N;
  endfunction

  task automatic clear_q();
    src.delete();
    sobq.delete();
    exp_q.delete();
  endtask

  task automatic add_block(input int base, input bit rnd);
    int s0;
    s0 = src.size();
    for (int k = 0; k < BLK; k++) begin
      src.push_back(rnd ? DW'($urandom) : DW'(base + k));
      sobq.push_back(k == 0);
    end
    for (int j = 0; j < BLK; j++) begin
      exp_q.push_back(src[s0 + tidx(j)]);
    end
  endtask

  // mode 0: out_ready=1, 1: random, 2: held low until two blocks stored
  task automatic run(input int mode, input string nm);
    int  idx;
    int  cyc;
    int  stall;
    int  gaps;
    int  flagerr;
    int  hold;
    int  bad;
    int  k;
    bit  released;
    bit  acc;
    idx = 0; cyc = 0; stall = 0; gaps = 0;
    flagerr = 0; hold = 0; released = 0;
    got.delete();
    while ((idx < src.size() || got.size() < exp_q.size()) && cyc < 4000) begin
      in_valid = idx < src.size();
      in_data  = in_valid ? src[idx] : '0;
      in_sob   = in_valid ? sobq[idx] : 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = released;
      endcase
      @(negedge clk);
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) stall++;
      if (mode == 2 && !released && idx == 2 * BLK) begin
        hold++;
        if (hold == 3) begin
          chk({nm, "_full_in_ready"}, int'(in_ready), 0);
          chk({nm, "_full_out_valid"}, int'(out_valid), 1);
          chk({nm, "_first_data"}, int'(out_data), int'(exp_q[0]));
          chk({nm, "_first_sob"}, int'(out_sob), 1);
          released = 1'b1;
        end
      end
      if (out_valid && out_ready) begin
        if (out_sob != (got.size() % BLK == 0) ||
            out_eob != (got.size() % BLK == BLK - 1)) flagerr++;
        got.push_back(out_data);
      end else if (got.size() > 0 && got.size() < exp_q.size()) begin
        gaps++;
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid  = 1'b0;
    in_sob    = 1'b0;
    out_ready = 1'b0;
    chk({nm, "_in_time"}, int'(cyc < 4000), 1);
    chk({nm, "_count"}, got.size(), exp_q.size());
    for (int b = 0; b < exp_q.size() / BLK; b++) begin
      bad = 0;
      for (int j = 0; j < BLK; j++) begin
        k = b * BLK + j;
        if (k >= got.size() || got[k] !== exp_q[k]) bad++;
      end
      chk($sformatf("%s_blk%0d_errs", nm, b), bad, 0);
    end
    chk({nm, "_sob_eob_errs"}, flagerr, 0);
    if (mode == 0) begin
      chk({nm, "_in_stalls"}, stall, 0);
      chk({nm, "_out_gaps"}, gaps, 0);
    end
    @(negedge clk);
    chk({nm, "_idle_valid"}, int'(out_valid), 0);
    chk({nm, "_idle_ready"}, int'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{0, 0, 1, 0};
    tbl[1] = '{1, 8, 0, 0};
    tbl[2] = '{7, 56, 0, 0};
    tbl[3] = '{8, 1, 0, 0};
    tbl[4] = '{10, 17, 0, 0};
    tbl[5] = '{27, 27, 0, 0};
    tbl[6] = '{56, 7, 0, 0};
    tbl[7] = '{63, 63, 0, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sob    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sob", int'(out_sob), 0);
    chk("rst_out_eob", int'(out_eob), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_err", int'(err_resync), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single block: latency and column-major order
    out_ready = 1'b1;
    for (int k = 0; k < BLK; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(k);
      in_sob   = (k == 0);
      @(negedge clk);
      if (k == BLK - 1) chk("t1_no_early_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_sob   = 1'b0;
    begin
      int gaps;
      int bad;
      gaps = 0;
      bad  = 0;
      for (int j = 0; j < BLK; j++) begin
        @(negedge clk);
        if (j == 0) chk("t1_latency_valid", int'(out_valid), 1);
        if (!out_valid) gaps++;
        rec_d[j] = int'(out_data);
        rec_s[j] = out_sob;
        rec_e[j] = out_eob;
        if (rec_d[j] != tidx(j)) bad++;
        @(posedge clk);
        #1;
      end
      chk("t1_gaps", gaps, 0);
      chk("t1_order_errs", bad, 0);
    end
    foreach (tbl[i]) begin
      chk($sformatf("t1_data_at_%0d", tbl[i].idx), rec_d[tbl[i].idx], tbl[i].data);
      chk($sformatf("t1_sob_at_%0d", tbl[i].idx), int'(rec_s[tbl[i].idx]), int'(tbl[i].sob));
      chk($sformatf("t1_eob_at_%0d", tbl[i].idx), int'(rec_e[tbl[i].idx]), int'(tbl[i].eob));
    end
    @(negedge clk);
    chk("t1_done_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;

    // back-to-back: 4 blocks, data k + 64*b
    clear_q();
    for (int b = 0; b < 4; b++) add_block(b * BLK, 1'b0);
    run(0, "b2b");
    chk("b2b_blk1_first", got.size() > BLK ? int'(got[BLK]) : -1, 64);
    chk("b2b_blk1_second", got.size() > BLK + 1 ? int'(got[BLK + 1]) : -1, 72);

    // both banks full under backpressure, then release
    clear_q();
    for (int b = 0; b < 3; b++) add_block(b * BLK, 1'b0);
    run(2, "hold");

    // random out_ready
    clear_q();
    for (int b = 0; b < 3; b++) add_block(0, 1'b1);
    run(1, "rnd");

    // resync: 20 stray samples, then a full block starting with sob
    clear_q();
    for (int k = 0; k < 20; k++) begin
      src.push_back(DW'(900 + k));
      sobq.push_back(k == 0);
    end
    add_block(500, 1'b0);
    chk("rs_err_before", int'(err_resync), 0);
    run(0, "rs");
    chk("rs_err_after", int'(err_resync), 1);

    // reset mid-readout at rd_ptr = 30
    out_ready = 1'b0;
    for (int k = 0; k < BLK; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(2000 + k);
      in_sob   = (k == 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_sob    = 1'b0;
    out_ready = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
    end
    chk("mr_data_at_30", int'(out_data), 2000 + tidx(30));
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", int'(out_valid), 0);
    chk("mr_in_ready", int'(in_ready), 1);
    chk("mr_out_sob", int'(out_sob), 0);
    chk("mr_err", int'(err_resync), 0);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // fresh block after reset
    clear_q();
    add_block(3000, 1'b0);
    run(0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/idct_transpose_buf.md
Name: idct_transpose_buf

Overview:
- Ping-pong transpose buffer. Sits between the row IDCT serial output and the column IDCT input.
- Accepts N×N blocks of DW-bit samples in row-major order. Emits each block in column-major order.
- Two banks: one block is read out while the next is written.
- Valid/ready handshakes on both sides.

Parameters:
- DW, 16, sample width in bits.
- N, 8, block dimension; must be a power of 2; block size is N*N samples.
- AW, 6, address width, equal to 2*log2(N).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  buffer can accept a sample
- in_sob  in  1  first sample of a block; qualified by in_valid & in_ready
- in_data  in  DW  input sample, row-major
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts
- out_data  out  DW  output sample, column-major
- out_sob  out  1  marks output index 0 of a block
- out_eob  out  1  marks output index N*N-1 of a block
- err_resync  out  1  sticky: a block was truncated by an early in_sob

Behaviour:
- Clock and reset: reset is rst_n, asynchronous, active-low; clock is clk.
- Reset state: both banks empty (full[1:0]=0), wb=0, rb=0, wr_ptr=0, rd_ptr=0, err_resync=0.
- Outputs during/after reset: in_ready=1, out_valid=0, out_sob=0, out_eob=0. out_data is don't-care while out_valid=0; it is 0 after reset.
- Bank contents are not reset.
- Input acceptance: a write occurs when in_valid & in_ready. in_ready = !full[wb], combinational.
- Write address: mem[wb][wr_ptr], where wr_ptr = r*N + c increments per write.
- Bank completion: on the write with wr_ptr = N*N-1, set full[wb], toggle wb, and set wr_ptr to 0.
- Resync: if in_sob=1 on an accepted write while wr_ptr≠0, the partial block is abandoned.
  - The sample is written at address 0 and wr_ptr becomes 1.
  - err_resync is set and held until reset.
  - in_sob=1 with wr_ptr=0 is normal and has no effect.
- Output: out_valid = full[rb]. out_data = mem[rb][addr_rd], a combinational read from the register array.
  - rd_ptr = c*N + r counts 0..N*N-1.
  - addr_rd swaps the rd_ptr fields: addr_rd = {rd_ptr[log2N-1:0], rd_ptr[AW-1:log2N]}.
  - Result: output order is column-major, e.g. for N=8: 0,8,16,…,56,1,9,…,63.
- out_sob = out_valid & (rd_ptr==0). out_eob = out_valid & (rd_ptr==N*N-1).
- Output transfer: occurs on out_valid & out_ready. rd_ptr increments on each transfer.
  - On the transfer with rd_ptr = N*N-1: clear full[rb], toggle rb, and set rd_ptr to 0.
- Backpressure: out_valid=1 with out_ready=0 holds out_data, rd_ptr and all flags stable.
- Latency: if the last sample of a block is written in cycle t and the read side is idle, out_valid rises in cycle t+1 with the block's sample 0.
- Throughput: one sample per clock sustained with out_ready held at 1.
- Simultaneous events:
  - Write completion and read completion in the same cycle both take effect: one full bit sets, the other clears.
  - Write and read can never target the same bank in the same cycle, because writes require !full and reads require full.
- Both banks full: in_ready=0 until the read side finishes its current block. No sample is dropped.
- Mid-operation reset: returns immediately to the reset state. Any partial or stored blocks are discarded.

Decomposition:
- Package idct_pkg holds DW, N, AW and the localparam BLK = N*N.
- Sub-module idct_tpose_bank holds one N*N×DW register array.
  - Inputs: write enable, write address, write data.
  - Output: asynchronous read data for a given read address.
  - Instantiated twice.
- Bank-select logic, pointer logic and the full flags live in idct_transpose_buf.

Test Plan:
- Single block, in_data=k for k=0..63, out_ready=1.
  - Expect out_valid 1 cycle after the last write.
  - Output sequence 0,8,16,…,56,1,9,…,63.
  - out_sob on value 0, out_eob on value 63.
- Back-to-back blocks, in_data = k+64·b for b=0..3, continuous in_valid, out_ready=1.
  - in_ready never drops; 256 outputs with no gaps.
  - Each block is transposed, e.g. block 1 begins 64,72,….
- out_ready=0 during two full input blocks: in_ready drops after sample 128.
  - Raise out_ready: first output is 0, and the third block is then accepted.
- Random out_ready with 50% duty: output stream equals a reference transpose and no samples are lost.
- in_sob pulsed at wr_ptr=20, then a full 64-sample block:
  - err_resync=1.
  - Output equals the transpose of the new block only.
- rst_n asserted mid-readout at rd_ptr=30:
  - out_valid=0 and in_ready=1 immediately.
  - A fresh block afterwards transposes correctly.
